arcade_input_mapper: RTL and testbench

//  Input front end for the arcade core top level, clocked in the 12 MHz clk_sys domain.
//  - Decodes hps_io ps2_key events into held key states.
//  - Merges them with per-player joystick words and applies the Horz/Vert control remap.
//  - Resolves opposing directions and emits one fixed-length coin pulse per coin press.
//  - Outputs drive the game core's player, start, coin and test inputs directly.

---
 rtl/arcade_input_mapper.sv | 198 +++++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mapper.sv
// Input front end for the arcade core: decodes PS/2 key events into held key
// states, merges them with joysticks, remaps for orientation and shapes the coin pulse.
module arcade_input_mapper #(
  parameter int COIN_PULSE = 1200000,
  parameter int CNT_W      = 21
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  output logic [4:0]  p1,
  output logic [4:0]  p2,
  output logic [1:0]  start,
  output logic        coin,
  output logic        test
);

  localparam int K_UP       = 0;
  localparam int K_DOWN     = 1;
  localparam int K_LEFT     = 2;
  localparam int K_RIGHT    = 3;
  localparam int K_FIRE     = 4;
  localparam int K_START1   = 5;
  localparam int K_START2   = 6;
  localparam int K_COIN_A   = 7;
  localparam int K_COIN_B   = 8;
  localparam int K_P2_UP    = 9;
  localparam int K_P2_DOWN  = 10;
  localparam int K_P2_LEFT  = 11;
  localparam int K_P2_RIGHT = 12;
  localparam int K_P2_FIRE  = 13;
  localparam int K_TEST     = 14;
  localparam int NKEYS      = 15;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COIN_PULSE - 1);

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_PULSE = 2'd1,
    C_GAP   = 2'd2
  } coin_state_e;

  logic             armed_q;
  logic             old_toggle_q;
  logic             key_event;
  logic [NKEYS-1:0] key_q;
  logic [NKEYS-1:0] key_sel;
  logic [7:0]       key_code;
  logic             key_ext;
  logic [3:0]       p1_dir;
  logic [3:0]       p2_dir;
  logic             coin_raw;
  logic             coin_raw_d_q;
  logic             coin_rise;
  coin_state_e      coin_state_q;
  coin_state_e      coin_state_d;
  logic [CNT_W-1:0] coin_cnt_q;
  logic [CNT_W-1:0] coin_cnt_d;
  logic             coin_q;
  logic             coin_d;
  logic             unused_bits;

  assign unused_bits = ^{joystick_0[15:8], joystick_1[15:8]};

  assign key_code  = ps2_key[7:0];
  assign key_ext   = ps2_key[8];
  // The first edge after reset only captures the toggle level, so a stale toggle is not an event.
  assign key_event = armed_q && (ps2_key[10] != old_toggle_q);

  always_comb begin
    key_sel = '0;
    case (key_code)
      8'h75:   key_sel[K_UP]       = 1'b1;
      8'h72:   key_sel[K_DOWN]     = 1'b1;
      8'h6B:   key_sel[K_LEFT]     = 1'b1;
      8'h74:   key_sel[K_RIGHT]    = 1'b1;
      8'h14:   key_sel[K_FIRE]     = 1'b1;
      8'h29:   key_sel[K_FIRE]     = !key_ext;
      8'h05:   key_sel[K_START1]   = !key_ext;
      8'h16:   key_sel[K_START1]   = !key_ext;
      8'h06:   key_sel[K_START2]   = !key_ext;
      8'h1E:   key_sel[K_START2]   = !key_ext;
      8'h2E:   key_sel[K_COIN_A]   = !key_ext;
      8'h36:   key_sel[K_COIN_B]   = !key_ext;
      8'h2D:   key_sel[K_P2_UP]    = !key_ext;
      8'h2B:   key_sel[K_P2_DOWN]  = !key_ext;
      8'h23:   key_sel[K_P2_LEFT]  = !key_ext;
      8'h34:   key_sel[K_P2_RIGHT] = !key_ext;
      8'h1C:   key_sel[K_P2_FIRE]  = !key_ext;
      8'h2C:   key_sel[K_TEST]     = !key_ext;
      default: key_sel = '0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      armed_q      <= 1'b0;
      old_toggle_q <= 1'b0;
      key_q        <= '0;
    end else begin
      armed_q      <= 1'b1;
      old_toggle_q <= ps2_key[10];
      if (key_event) begin
        key_q <= (key_q & ~key_sel) | (key_sel & {NKEYS{ps2_key[9]}});
      end
    end
  end

  // dir is {up,down,left,right}; rotation happens before opposing directions are cancelled.
  function automatic logic [4:0] map_player(input logic fire, input logic [3:0] dir,
                                            input logic rot);
    logic [3:0] r;
    r = rot ? {dir[1], dir[0], dir[2], dir[3]} : dir;
    if (r[3] && r[2]) r[3:2] = 2'b00;
    if (r[1] && r[0]) r[1:0] = 2'b00;
    return {fire, r};
  endfunction

  assign p1_dir = joystick_0[3:0]
                | {key_q[K_UP], key_q[K_DOWN], key_q[K_LEFT], key_q[K_RIGHT]};
  assign p2_dir = joystick_1[3:0]
                | {key_q[K_P2_UP], key_q[K_P2_DOWN], key_q[K_P2_LEFT], key_q[K_P2_RIGHT]};

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      p1    <= '0;
      p2    <= '0;
      start <= '0;
      test  <= 1'b0;
    end else begin
      p1       <= map_player(key_q[K_FIRE] | joystick_0[4], p1_dir, rotate);
      p2       <= map_player(key_q[K_P2_FIRE] | joystick_1[4], p2_dir, rotate);
      start[0] <= key_q[K_START1] | joystick_0[5] | joystick_1[5];
      start[1] <= key_q[K_START2] | joystick_0[6] | joystick_1[6];
      test     <= key_q[K_TEST];
    end
  end

  assign coin_raw  = key_q[K_COIN_A] | key_q[K_COIN_B] | joystick_0[7] | joystick_1[7];
  assign coin_rise = coin_raw & ~coin_raw_d_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      coin_raw_d_q <= 1'b0;
      coin_state_q <= C_IDLE;
      coin_cnt_q   <= '0;
      coin_q       <= 1'b0;
    end else begin
      coin_raw_d_q <= coin_raw;
      coin_state_q <= coin_state_d;
      coin_cnt_q   <= coin_cnt_d;
      coin_q       <= coin_d;
    end
  end

  // Rises arriving outside IDLE are dropped; the GAP phase enforces the minimum low time.
  always_comb begin
    coin_state_d = coin_state_q;
    coin_cnt_d   = coin_cnt_q;
    coin_d       = coin_q;
    case (coin_state_q)
      C_IDLE: begin
        if (coin_rise) begin
          coin_state_d = C_PULSE;
          coin_cnt_d   = '0;
          coin_d       = 1'b1;
        end
      end
      C_PULSE: begin
        if (coin_cnt_q == CNT_LAST) begin
          coin_state_d = C_GAP;
          coin_cnt_d   = '0;
          coin_d       = 1'b0;
        end else begin
          coin_cnt_d = coin_cnt_q + CNT_W'(1);
        end
      end
      C_GAP: begin
        if (coin_cnt_q == CNT_LAST) begin
          coin_state_d = C_IDLE;
          coin_cnt_d   = '0;
        end else begin
          coin_cnt_d = coin_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        coin_state_d = C_IDLE;
        coin_cnt_d   = '0;
        coin_d       = 1'b0;
      end
    endcase
  end

  assign coin = coin_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench for arcade_input_mapper: directed scenarios plus random
// stimulus, all compared against a key-name based reference model.
module tb_arcade_input_mapper;

  localparam int P = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        rotate;
  logic [4:0]  p1;
  logic [4:0]  p2;
  logic [1:0]  start;
  logic        coin;
  logic        test;
  logic [13:0] dut_out;

  arcade_input_mapper #(.COIN_PULSE(P), .CNT_W(3)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_key    (ps2_key),
    .joystick_0 (joystick_0),
    .joystick_1 (joystick_1),
    .rotate     (rotate),
    .p1         (p1),
    .p2         (p2),
    .start      (start),
    .coin       (coin),
    .test       (test)
  );

  assign dut_out = {p1, p2, start, coin, test};

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_key[string];
  bit          m_armed;
  bit          m_tog;
  bit          m_raw_d;
  bit          m_active;
  int          m_since;
  logic [13:0] exp_all;

  logic [10:0] cur_ps2;
  logic [15:0] cur_j0;
  logic [15:0] cur_j1;
  logic        cur_rot;

  string key_names[15] = '{"up", "down", "left", "right", "fire", "start1", "start2",
                           "coin_a", "coin_b", "p2_up", "p2_down", "p2_left", "p2_right",
                           "p2_fire", "test"};
  logic [7:0] code_pool[20] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h29, 8'h05, 8'h06,
                                8'h16, 8'h1E, 8'h2E, 8'h36, 8'h2D, 8'h2B, 8'h23, 8'h34,
                                8'h1C, 8'h2C, 8'h00, 8'h5A};

  function automatic string key_name(input logic [7:0] code, input logic ext);
    string s;
    s = "";
    case (code)
      8'h75: s = "up";
      8'h72: s = "down";
      8'h6B: s = "left";
      8'h74: s = "right";
      8'h14: s = "fire";
      default: s = "";
    endcase
    if (!ext) begin
      case (code)
        8'h29: s = "fire";
        8'h05: s = "start1";
        8'h16: s = "start1";
        8'h06: s = "start2";
        8'h1E: s = "start2";
        8'h2E: s = "coin_a";
        8'h36: s = "coin_b";
        8'h2D: s = "p2_up";
        8'h2B: s = "p2_down";
        8'h23: s = "p2_left";
        8'h34: s = "p2_right";
        8'h1C: s = "p2_fire";
        8'h2C: s = "test";
        default: ;
      endcase
    end
    return s;
  endfunction

  function automatic logic [4:0] player(input bit f, input bit u, input bit d, input bit l,
                                        input bit r, input bit rot);
    bit uu, dd, ll, rr;
    if (rot) begin
      uu = l; dd = r; ll = d; rr = u;
    end else begin
      uu = u; dd = d; ll = l; rr = r;
    end
    if (uu && dd) begin uu = 0; dd = 0; end
    if (ll && rr) begin ll = 0; rr = 0; end
    return {f, uu, dd, ll, rr};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_key[key_names[i]] = 1'b0;
    m_armed  = 0;
    m_tog    = 0;
    m_raw_d  = 0;
    m_active = 0;
    m_since  = 0;
    exp_all  = '0;
  endtask

  // Apply one cycle of inputs, advance the model, return 1 time unit after the edge.
  task automatic step(input logic [10:0] k, input logic [15:0] a, input logic [15:0] b,
                      input logic r);
    logic [4:0] e1, e2;
    logic [1:0] es;
    bit raw, rise, ecoin, etest;
    string nm;
    ps2_key = k; joystick_0 = a; joystick_1 = b; rotate = r;
    cur_ps2 = k; cur_j0 = a; cur_j1 = b; cur_rot = r;
    e1 = player(m_key["fire"] | a[4], m_key["up"] | a[3], m_key["down"] | a[2],
                m_key["left"] | a[1], m_key["right"] | a[0], r);
    e2 = player(m_key["p2_fire"] | b[4], m_key["p2_up"] | b[3], m_key["p2_down"] | b[2],
                m_key["p2_left"] | b[1], m_key["p2_right"] | b[0], r);
    es = {m_key["start2"] | a[6] | b[6], m_key["start1"] | a[5] | b[5]};
    etest = m_key["test"];
    raw  = m_key["coin_a"] | m_key["coin_b"] | a[7] | b[7];
    rise = raw && !m_raw_d;
    // A pulse of P cycles plus its lockout spans 2P+1 edges from acceptance.
    if (m_active) begin
      m_since++;
      if (m_since > 2 * P) m_active = 0;
    end
    if (rise && !m_active) begin
      m_active = 1;
      m_since  = 0;
    end
    ecoin = m_active && (m_since < P);
    if (m_armed && (k[10] != m_tog)) begin
      nm = key_name(k[7:0], k[8]);
      if (nm != "") m_key[nm] = k[9];
    end
    m_tog   = k[10];
    m_armed = 1;
    m_raw_d = raw;
    exp_all = {e1, e2, es, ecoin, etest};
    @(posedge clk_sys);
    #1;
  endtask

  task automatic key_evt(input bit pressed, input bit ext, input logic [7:0] code);
    step({~cur_ps2[10], pressed, ext, code}, cur_j0, cur_j1, cur_rot);
  endtask

  task automatic test_reset();
    reset_n = 0;
    model_reset();
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
    joystick_0 = '0; joystick_1 = '0; rotate = 0;
    cur_ps2 = ps2_key; cur_j0 = '0; cur_j1 = '0; cur_rot = 0;
    repeat (3) @(posedge clk_sys);
    #1;
    if (dut_out !== 14'h0) begin
      errors++; $display("FAIL reset_outputs out=%h exp=%h", dut_out, 14'h0);
    end
    checks++;
    reset_n = 1;
    repeat (3) begin
      step(cur_ps2, cur_j0, cur_j1, cur_rot);
      if (dut_out !== 14'h0 || dut_out !== exp_all) begin
        errors++; $display("FAIL reset_no_event out=%h exp=%h", dut_out, 14'h0);
      end
      checks++;
    end
    step({1'b0, 1'b1, 1'b0, 8'h75}, cur_j0, cur_j1, cur_rot);
    if (p1[3] !== 1'b0) begin
      errors++; $display("FAIL first_event_edge1 p1_up=%b exp=0", p1[3]);
    end
    checks++;
    step(cur_ps2, cur_j0, cur_j1, cur_rot);
    if (p1[3] !== 1'b1 || dut_out !== exp_all) begin
      errors++; $display("FAIL first_event_edge2 out=%h exp=%h", dut_out, exp_all);
    end
    checks++;
    key_evt(0, 0, 8'h75);
    step(cur_ps2, cur_j0, cur_j1, cur_rot);
  endtask

  task automatic test_ext_up();
    key_evt(1, 1, 8'h75);
    step(cur_ps2, cur_j0, cur_j1, cur_rot);
    if (p1 !== 5'b01000 || dut_out !== exp_all) begin
      errors++; $display("FAIL ext_up_press out=%h exp=%h", dut_out, exp_all);
    end
    checks++;
    key_evt(0, 1, 8'h75);
    step(cur_ps2, cur_j0, cur_j1, cur_rot);
    if (p1 !== 5'b00000 || dut_out !== exp_all) begin
      errors++; $display("FAIL ext_up_release out=%h exp=%h", dut_out, exp_all);
    end
    checks++;
  endtask

  task automatic test_fire();
    key_evt(1, 0, 8'h29);
    step(cur_ps2, cur_j0, cur_j1, cur_rot);
    if (p1[4] !== 1'b1 || dut_out !== exp_all) begin
      errors++; $display("FAIL space_fire out=%h exp=%h", dut_out, exp_all);
    end
    checks++;
    key_evt(0, 0, 8'h29);
    key_evt(1, 1, 8'h29);
    step(cur_ps2, cur_j0, cur_j1, cur_rot);
    if (p1[4] !== 1'b0 || dut_out !== exp_all) begin
      errors++; $display("FAIL ext_space_ignored out=%h exp=%h", dut_out, exp_all);
    end
    checks++;
    key_evt(1, 1, 8'h14);
    step(cur_ps2, cur_j0, cur_j1, cur_rot);
    if (p1[4] !== 1'b1 || dut_out !== exp_all) begin
      errors++; $display("FAIL ext_ctrl_fire out=%h exp=%h", dut_out, exp_all);
    end
    checks++;
    key_evt(0, 0, 8'h14);
    step(cur_ps2, cur_j0, cur_j1, cur_rot);
  endtask

  task automatic test_rotate_socd();
    step(cur_ps2, 16'h000A, cur_j1, 1'b0);
    if (p1 !== 5'b01010 || dut_out !== exp_all) begin
      errors++; $display("FAIL joy_lu_norot out=%h exp=%h", dut_out, exp_all);
    end
    checks++;
    step(cur_ps2, 16'h000A, cur_j1, 1'b1);
    if (p1 !== 5'b01001 || dut_out !== exp_all) begin
      errors++; $display("FAIL joy_lu_rot out=%h exp=%h", dut_out, exp_all);
    end
    checks++;
    step(cur_ps2, 16'h000C, cur_j1, 1'b0);
    if (p1 !== 5'b00000 || dut_out !== exp_all) begin
      errors++; $display("FAIL socd_ud out=%h exp=%h", dut_out, exp_all);
    end
    checks++;
    step(cur_ps2, 16'h0003, 16'h0013, 1'b0);
    if (p1 !== 5'b00000 || p2 !== 5'b10000 || dut_out !== exp_all) begin
      errors++; $display("FAIL socd_lr out=%h exp=%h", dut_out, exp_all);
    end
    checks++;
    step(cur_ps2, 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic test_p2_start_test();
    key_evt(1, 0, 8'h2D);
    key_evt(1, 0, 8'h16);
    key_evt(1, 0, 8'h2C);
    step(cur_ps2, cur_j0, 16'h0040, cur_rot);
    if (p2[3] !== 1'b1 || start !== 2'b11 || test !== 1'b1 || dut_out !== exp_all) begin
      errors++; $display("FAIL p2_start_test out=%h exp=%h", dut_out, exp_all);
    end
    checks++;
    key_evt(0, 0, 8'h2D);
    key_evt(0, 0, 8'h16);
    key_evt(0, 0, 8'h2C);
    step(cur_ps2, cur_j0, 16'h0000, cur_rot);
    if (dut_out !== 14'h0 || dut_out !== exp_all) begin
      errors++; $display("FAIL p2_start_release out=%h exp=%h", dut_out, exp_all);
    end
    checks++;
  endtask

  task automatic test_coin();
    int high;
    high = 0;
    key_evt(1, 0, 8'h2E);
    repeat (20) begin
      step(cur_ps2, cur_j0, cur_j1, cur_rot);
      if (coin === 1'b1) high++;
      if (dut_out !== exp_all) begin
        errors++; $display("FAIL coin_hold out=%h exp=%h", dut_out, exp_all);
      end
      checks++;
    end
    if (high !== P) begin
      errors++; $display("FAIL coin_width high=%0d exp=%0d", high, P);
    end
    checks++;
    key_evt(0, 0, 8'h2E);
    repeat (3) step(cur_ps2, cur_j0, cur_j1, cur_rot);
  endtask

  task automatic test_back_to_back();
    // E0 accept, E1-E3 high, E4 low, E7 rise dropped, E9 rise accepted
    logic [15:0] seq[10] = '{16'h80, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                             16'h80, 16'h0, 16'h80};
    logic exp_c[10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 10; i++) begin
      step(cur_ps2, seq[i], cur_j1, cur_rot);
      if (coin !== exp_c[i] || dut_out !== exp_all) begin
        errors++; $display("FAIL coin_b2b_e%0d coin=%b exp=%b", i, coin, exp_c[i]);
      end
      checks++;
    end
    repeat (10) step(cur_ps2, 16'h0, cur_j1, cur_rot);
  endtask

  task automatic test_reset_mid_pulse();
    int high;
    high = 0;
    step(cur_ps2, 16'h0, 16'h80, cur_rot);
    step(cur_ps2, 16'h0, 16'h80, cur_rot);
    reset_n = 0;
    #2;
    if (coin !== 1'b0 || dut_out !== 14'h0) begin
      errors++; $display("FAIL reset_mid_pulse out=%h exp=%h", dut_out, 14'h0);
    end
    checks++;
    model_reset();
    joystick_1 = '0;
    cur_j1 = '0;
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n = 1;
    step(cur_ps2, 16'h0, 16'h0, cur_rot);
    repeat (12) begin
      step(cur_ps2, 16'h0, 16'h80, cur_rot);
      if (coin === 1'b1) high++;
      if (dut_out !== exp_all) begin
        errors++; $display("FAIL post_reset_coin out=%h exp=%h", dut_out, exp_all);
      end
      checks++;
    end
    if (high !== P) begin
      errors++; $display("FAIL post_reset_width high=%0d exp=%0d", high, P);
    end
    checks++;
    step(cur_ps2, 16'h0, 16'h0, cur_rot);
  endtask

  task automatic test_random();
    logic [10:0] k;
    logic [15:0] a, b;
    logic r;
    r = 0;
    for (int i = 0; i < 600; i++) begin
      k = cur_ps2;
      if ($urandom_range(0, 3) == 0) begin
        k[10]  = ~k[10];
        k[9]   = ($urandom_range(0, 2) != 0);
        k[8]   = $urandom_range(0, 1);
        k[7:0] = code_pool[$urandom_range(0, 19)];
      end else if ($urandom_range(0, 3) == 0) begin
        k[9:0] = 10'($urandom);
      end
      a = 16'($urandom_range(0, 127));
      b = 16'($urandom_range(0, 127));
      if ($urandom_range(0, 15) == 0) a[7] = 1'b1;
      if ($urandom_range(0, 15) == 0) b[7] = 1'b1;
      a[15:8] = 8'($urandom);
      if ($urandom_range(0, 7) == 0) r = ~r;
      step(k, a, b, r);
      if (dut_out !== exp_all) begin
        errors++; $display("FAIL random_%0d out=%h exp=%h", i, dut_out, exp_all);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_ext_up();
    test_fire();
    test_rotate_socd();
    test_p2_start_test();
    test_coin();
    test_back_to_back();
    test_reset_mid_pulse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
